ex_wb_buffer: RTL and testbench
===============================

Name: ex_wb_buffer

Overview:
- Two-entry elastic buffer directly downstream of the R-type execute unit, between execute results and the register-file write port.
- Captures each execute result (write address, write data, write enable) with a valid/ready handshake and presents it in order to writeback.
- Absorbs a one-cycle writeback stall without dropping results.
- Offers combinational bypass lookups so decode/operand fetch can read results that are still pending.

Parameters:
- DATA_W, 32, width of result data (matches `DATA_WIDTH).
- ADDR_W, 5, register address width (x0..x31).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  discard all buffered entries (pipeline redirect).
- ex_valid_i  in  1  execute presents a result this cycle.
- ex_ready_o  out  1  buffer can accept a result this cycle.
- ex_waddr_i  in  ADDR_W  destination register.
- ex_wdata_i  in  DATA_W  result value.
- ex_we_i  in  1  result writes the register file.
- wb_valid_o  out  1  head entry available to writeback.
- wb_ready_i  in  1  writeback consumes head this cycle.
- wb_waddr_o  out  ADDR_W  head destination.
- wb_wdata_o  out  DATA_W  head data.
- wb_we_o  out  1  head write enable; always 0 when wb_waddr_o==0.
- fwd_raddr1_i  in  ADDR_W  bypass lookup address, port 1.
- fwd_raddr2_i  in  ADDR_W  bypass lookup address, port 2.
- fwd_hit1_o  out  1  port 1 matches a pending write.
- fwd_data1_o  out  DATA_W  port 1 bypass data.
- fwd_hit2_o  out  1  port 2 matches a pending write.
- fwd_data2_o  out  DATA_W  port 2 bypass data.
- count_o  out  2  number of valid entries (0..2).

Behaviour:
- Storage: 2 entries {waddr, wdata, we}, plus a read pointer, a write pointer (each 1 bit, wrapping 1->0) and a 2-bit count.
- Reset (rst_i=1 at edge): count=0, pointers=0, all entry fields=0.
  - Resulting outputs: ex_ready_o=1, wb_valid_o=0, wb_waddr_o=0, wb_wdata_o=0, wb_we_o=0, fwd_hit*=0, fwd_data*=0, count_o=0.
  - Reset overrides flush and any handshake in the same cycle.
- ex_ready_o = (count<2). Combinational from count only; must not depend on wb_ready_i.
- push = ex_valid_i & ex_ready_o.
  - Writes the entry at the write pointer; write pointer advances.
  - Entries with ex_we_i=0 are still stored and passed through, keeping order.
- wb_valid_o = (count!=0).
  - wb_* outputs show the head entry; all forced to 0 when empty.
  - wb_we_o = head.we & (head.waddr!=0).
- pop = wb_valid_o & wb_ready_i. Read pointer advances.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together (count==1 only, since ex_ready_o=0 when full): count unchanged, and the pushed entry becomes the new head next cycle.
  - neither: unchanged.
- Latency: a result pushed at edge N is visible on wb_* in cycle N+1. There is no bypass from ex_* inputs straight to wb_*.
- Full (count==2): ex_ready_o=0; ex_valid_i is ignored. A pop that cycle makes ex_ready_o=1 next cycle.
- Empty: wb_valid_o=0; wb_ready_i is ignored.
- flush_i=1 at edge (no reset): count=0 and pointers=0.
  - Any push or pop in that same cycle is discarded.
  - Outputs show the empty state next cycle.
- Forwarding, per port, fully combinational:
  - An entry is a candidate if it is valid, its we=1, and its waddr equals fwd_raddr and is non-zero.
  - If both entries match, the younger (most recently pushed) entry wins.
  - With no match: fwd_hit=0 and fwd_data=0. A lookup of address 0 never hits.
  - Forwarding sees only buffered entries, not ex_* inputs of the current cycle.
- Data is stored verbatim. No arithmetic on data; the pointer/count arithmetic wraps modulo its width.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles -> ex_ready_o=1, wb_valid_o=0, count_o=0, all data outputs 0.
- Single pass: push {waddr=5, wdata=32'h0000_00AA, we=1}, wb_ready_i=1 -> next cycle wb_valid_o=1, wb_waddr_o=5, wb_wdata_o=0xAA, wb_we_o=1; the cycle after, count_o=0.
- Stall/fill: wb_ready_i=0; push {3,0x11,1} then {3,0x22,1} -> count_o=2, ex_ready_o=0; a third push {4,0x33,1} is ignored.
  - fwd_raddr1_i=3 -> fwd_hit1_o=1, fwd_data1_o=0x22 (younger wins).
  - Release wb_ready_i -> heads 0x11 then 0x22 in order.
- x0 suppression: push {0, 0xDEAD_BEEF, 1} -> wb_we_o=0 while it is head; fwd_raddr2_i=0 -> fwd_hit2_o=0.
- Simultaneous push/pop at count=1 (head {7,0x70,1}): push {8,0x80,1} with wb_ready_i=1 -> count_o stays 1; next head {8,0x80,1}.
- Flush: count_o=2 with push and pop asserted, flush_i=1 -> next cycle count_o=0, wb_valid_o=0, ex_ready_o=1, fwd_hit*=0.

Source files
------------

// File: rtl/ex_wb_buffer.sv
// ex_wb_buffer: two-entry elastic buffer between the R-type execute unit and
// the register-file write port, with in-order drain and bypass lookups.
module ex_wb_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [ADDR_W-1:0] ex_waddr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_we_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [ADDR_W-1:0] wb_waddr_o,
  output logic [DATA_W-1:0] wb_wdata_o,
  output logic              wb_we_o,
  input  logic [ADDR_W-1:0] fwd_raddr1_i,
  input  logic [ADDR_W-1:0] fwd_raddr2_i,
  output logic              fwd_hit1_o,
  output logic [DATA_W-1:0] fwd_data1_o,
  output logic              fwd_hit2_o,
  output logic [DATA_W-1:0] fwd_data2_o,
  output logic [1:0]        count_o
);

  typedef struct packed {
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              we;
  } entry_t;

  entry_t     mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;

  logic   push;
  logic   pop;
  entry_t head;
  entry_t young;
  entry_t old;
  logic   young_vld;
  logic   old_vld;
  logic   y1, o1, y2, o2;

  // A buffered entry satisfies a lookup only if it is live, writes, and targets a non-zero register
  function automatic logic fwd_match(input entry_t e, input logic vld,
                                     input logic [ADDR_W-1:0] ra);
    return vld & e.we & (e.waddr == ra) & (ra != '0);
  endfunction

  // Handshake and head presentation, all derived from stored state only
  always_comb begin
    ex_ready_o = 1'b0;
    wb_valid_o = 1'b0;
    wb_waddr_o = '0;
    wb_wdata_o = '0;
    wb_we_o    = 1'b0;
    head       = mem[rd_ptr];
    ex_ready_o = (count != 2'd2);
    wb_valid_o = (count != 2'd0);
    if (wb_valid_o) begin
      wb_waddr_o = head.waddr;
      wb_wdata_o = head.wdata;
      wb_we_o    = head.we & (head.waddr != '0);
    end
    push    = ex_valid_i & ex_ready_o;
    pop     = wb_valid_o & wb_ready_i;
    count_o = count;
  end

  // Bypass lookup: the most recently pushed entry sits just behind the write pointer
  always_comb begin
    young       = mem[~wr_ptr];
    old         = mem[rd_ptr];
    young_vld   = (count != 2'd0);
    old_vld     = (count == 2'd2);
    y1          = fwd_match(young, young_vld, fwd_raddr1_i);
    o1          = fwd_match(old, old_vld, fwd_raddr1_i);
    y2          = fwd_match(young, young_vld, fwd_raddr2_i);
    o2          = fwd_match(old, old_vld, fwd_raddr2_i);
    fwd_hit1_o  = y1 | o1;
    fwd_hit2_o  = y2 | o2;
    fwd_data1_o = '0;
    fwd_data2_o = '0;
    if (y1)      fwd_data1_o = young.wdata;
    else if (o1) fwd_data1_o = old.wdata;
    if (y2)      fwd_data2_o = young.wdata;
    else if (o2) fwd_data2_o = old.wdata;
  end

  // Storage, pointers and occupancy; reset beats flush, flush beats handshakes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush_i) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{waddr: ex_waddr_i, wdata: ex_wdata_i, we: ex_we_i};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_wb_buffer.sv
// Bench for ex_wb_buffer: directed vector table followed by random traffic
// checked against a queue-based model of the buffer.
module tb_ex_wb_buffer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst, flush, ex_valid, ex_ready, ex_we;
  logic [ADDR_W-1:0] ex_waddr;
  logic [DATA_W-1:0] ex_wdata;
  logic              wb_valid, wb_ready, wb_we;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic [ADDR_W-1:0] raddr1, raddr2;
  logic              hit1, hit2;
  logic [DATA_W-1:0] data1, data2;
  logic [1:0]        count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_wb_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
    .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_we_i(ex_we),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
    .wb_waddr_o(wb_waddr), .wb_wdata_o(wb_wdata), .wb_we_o(wb_we),
    .fwd_raddr1_i(raddr1), .fwd_raddr2_i(raddr2),
    .fwd_hit1_o(hit1), .fwd_data1_o(data1),
    .fwd_hit2_o(hit2), .fwd_data2_o(data2),
    .count_o(count)
  );

  typedef struct {
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              we;
  } ent_t;

  ent_t q[$];

  typedef struct {
    bit chk;
    bit rst; bit flush; bit v; int waddr; logic [31:0] wdata; bit we; bit rdy; int r1; int r2;
    bit e_rdy; bit e_val; int e_waddr; logic [31:0] e_wdata; bit e_we;
    bit e_h1; logic [31:0] e_d1; bit e_h2; logic [31:0] e_d2; int e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model lookup: newest matching entry wins
  task automatic model_fwd(input logic [ADDR_W-1:0] ra, output logic h, output logic [DATA_W-1:0] d);
    h = 1'b0;
    d = '0;
    if (ra != 0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!h && q[i].we && q[i].waddr == ra) begin
          h = 1'b1;
          d = q[i].wdata;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic h1, h2;
    logic [DATA_W-1:0] d1, d2;
    int sz;
    sz = q.size();
    model_fwd(raddr1, h1, d1);
    model_fwd(raddr2, h2, d2);
    check({tag, ".ready"}, 64'(ex_ready), 64'(sz < 2));
    check({tag, ".valid"}, 64'(wb_valid), 64'(sz != 0));
    check({tag, ".count"}, 64'(count), 64'(sz));
    check({tag, ".waddr"}, 64'(wb_waddr), sz != 0 ? 64'(q[0].waddr) : 64'd0);
    check({tag, ".wdata"}, 64'(wb_wdata), sz != 0 ? 64'(q[0].wdata) : 64'd0);
    check({tag, ".we"}, 64'(wb_we), sz != 0 ? 64'(q[0].we && q[0].waddr != 0) : 64'd0);
    check({tag, ".hit1"}, 64'(hit1), 64'(h1));
    check({tag, ".data1"}, 64'(data1), 64'(d1));
    check({tag, ".hit2"}, 64'(hit2), 64'(h2));
    check({tag, ".data2"}, 64'(data2), 64'(d2));
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_edge();
    bit do_push, do_pop;
    ent_t e;
    if (rst || flush) begin
      q.delete();
    end else begin
      do_push = ex_valid && q.size() < 2;
      do_pop  = wb_ready && q.size() != 0;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.waddr = ex_waddr;
        e.wdata = ex_wdata;
        e.we    = ex_we;
        q.push_back(e);
      end
    end
  endtask

  task automatic finish_cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit chk, input bit r, input bit f, input bit v, input int wa,
                     input logic [31:0] wd, input bit we, input bit rdy, input int r1, input int r2,
                     input bit e_rdy, input bit e_val, input int e_wa, input logic [31:0] e_wd,
                     input bit e_we, input bit e_h1, input logic [31:0] e_d1,
                     input bit e_h2, input logic [31:0] e_d2, input int e_cnt);
    vec_t t;
    t.chk = chk; t.rst = r; t.flush = f; t.v = v; t.waddr = wa; t.wdata = wd; t.we = we;
    t.rdy = rdy; t.r1 = r1; t.r2 = r2;
    t.e_rdy = e_rdy; t.e_val = e_val; t.e_waddr = e_wa; t.e_wdata = e_wd; t.e_we = e_we;
    t.e_h1 = e_h1; t.e_d1 = e_d1; t.e_h2 = e_h2; t.e_d2 = e_d2; t.e_cnt = e_cnt;
    vecs.push_back(t);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_waddr = '0; ex_wdata = '0; ex_we = 1'b0;
    wb_ready = 1'b0; raddr1 = '0; raddr2 = '0;

    //   chk rst fl  v  wa  wdata          we rdy r1 r2 | rdy val wa wdata         we h1 d1     h2 d2     cnt
    add(0, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0,   1, 0, 0, 32'h0,          0, 0, 32'h0,  0, 32'h0,  0);
    add(1, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0,   1, 0, 0, 32'h0,          0, 0, 32'h0,  0, 32'h0,  0);
    add(1, 0, 0, 1, 5, 32'hAA,         1, 1, 5, 0,   1, 0, 0, 32'h0,          0, 0, 32'h0,  0, 32'h0,  0);
    add(1, 0, 0, 0, 0, 32'h0,          0, 1, 5, 0,   1, 1, 5, 32'hAA,         1, 1, 32'hAA, 0, 32'h0,  1);
    add(1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0,   1, 0, 0, 32'h0,          0, 0, 32'h0,  0, 32'h0,  0);
    add(1, 0, 0, 1, 3, 32'h11,         1, 0, 0, 0,   1, 0, 0, 32'h0,          0, 0, 32'h0,  0, 32'h0,  0);
    add(1, 0, 0, 1, 3, 32'h22,         1, 0, 3, 0,   1, 1, 3, 32'h11,         1, 1, 32'h11, 0, 32'h0,  1);
    add(1, 0, 0, 1, 4, 32'h33,         1, 0, 3, 4,   0, 1, 3, 32'h11,         1, 1, 32'h22, 0, 32'h0,  2);
    add(1, 0, 0, 0, 0, 32'h0,          0, 1, 3, 4,   0, 1, 3, 32'h11,         1, 1, 32'h22, 0, 32'h0,  2);
    add(1, 0, 0, 0, 0, 32'h0,          0, 1, 3, 0,   1, 1, 3, 32'h22,         1, 1, 32'h22, 0, 32'h0,  1);
    add(1, 0, 0, 1, 0, 32'hDEADBEEF,   1, 0, 0, 0,   1, 0, 0, 32'h0,          0, 0, 32'h0,  0, 32'h0,  0);
    add(1, 0, 0, 0, 0, 32'h0,          0, 1, 0, 0,   1, 1, 0, 32'hDEADBEEF,   0, 0, 32'h0,  0, 32'h0,  1);
    add(1, 0, 0, 1, 7, 32'h70,         1, 0, 0, 0,   1, 0, 0, 32'h0,          0, 0, 32'h0,  0, 32'h0,  0);
    add(1, 0, 0, 1, 8, 32'h80,         1, 1, 7, 8,   1, 1, 7, 32'h70,         1, 1, 32'h70, 0, 32'h0,  1);
    add(1, 0, 0, 0, 0, 32'h0,          0, 0, 7, 8,   1, 1, 8, 32'h80,         1, 0, 32'h0,  1, 32'h80, 1);
    add(1, 0, 0, 1, 9, 32'h90,         1, 0, 0, 0,   1, 1, 8, 32'h80,         1, 0, 32'h0,  0, 32'h0,  1);
    add(1, 0, 1, 1, 10, 32'hA0,        1, 1, 8, 9,   0, 1, 8, 32'h80,         1, 1, 32'h80, 1, 32'h90, 2);
    add(1, 0, 0, 0, 0, 32'h0,          0, 0, 8, 9,   1, 0, 0, 32'h0,          0, 0, 32'h0,  0, 32'h0,  0);
    add(1, 0, 0, 1, 6, 32'h66,         0, 0, 6, 0,   1, 0, 0, 32'h0,          0, 0, 32'h0,  0, 32'h0,  0);
    add(1, 0, 0, 0, 0, 32'h0,          0, 1, 6, 0,   1, 1, 6, 32'h66,         0, 0, 32'h0,  0, 32'h0,  1);
    add(1, 0, 0, 1, 6, 32'h55,         1, 0, 0, 0,   1, 0, 0, 32'h0,          0, 0, 32'h0,  0, 32'h0,  0);
    add(1, 1, 1, 1, 2, 32'h12,         1, 1, 6, 0,   1, 1, 6, 32'h55,         1, 1, 32'h55, 0, 32'h0,  1);
    add(1, 0, 0, 0, 0, 32'h0,          0, 0, 6, 2,   1, 0, 0, 32'h0,          0, 0, 32'h0,  0, 32'h0,  0);

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      rst      = vecs[i].rst;
      flush    = vecs[i].flush;
      ex_valid = vecs[i].v;
      ex_waddr = ADDR_W'(vecs[i].waddr);
      ex_wdata = vecs[i].wdata;
      ex_we    = vecs[i].we;
      wb_ready = vecs[i].rdy;
      raddr1   = ADDR_W'(vecs[i].r1);
      raddr2   = ADDR_W'(vecs[i].r2);
      @(negedge clk);
      if (vecs[i].chk) begin
        check($sformatf("v%0d.ready", i), 64'(ex_ready), 64'(vecs[i].e_rdy));
        check($sformatf("v%0d.valid", i), 64'(wb_valid), 64'(vecs[i].e_val));
        check($sformatf("v%0d.waddr", i), 64'(wb_waddr), 64'(vecs[i].e_waddr));
        check($sformatf("v%0d.wdata", i), 64'(wb_wdata), 64'(vecs[i].e_wdata));
        check($sformatf("v%0d.we", i), 64'(wb_we), 64'(vecs[i].e_we));
        check($sformatf("v%0d.hit1", i), 64'(hit1), 64'(vecs[i].e_h1));
        check($sformatf("v%0d.data1", i), 64'(data1), 64'(vecs[i].e_d1));
        check($sformatf("v%0d.hit2", i), 64'(hit2), 64'(vecs[i].e_h2));
        check($sformatf("v%0d.data2", i), 64'(data2), 64'(vecs[i].e_d2));
        check($sformatf("v%0d.count", i), 64'(count), 64'(vecs[i].e_cnt));
        check_model($sformatf("m%0d", i));
      end
      finish_cycle();
    end

    // Random traffic with narrow addresses so both bypass paths and x0 get exercised
    for (int c = 0; c < 2000; c++) begin
      rst      = ($urandom_range(0, 79) == 0);
      flush    = ($urandom_range(0, 24) == 0);
      ex_valid = ($urandom_range(0, 9) < 7);
      ex_waddr = ADDR_W'($urandom_range(0, 7));
      ex_wdata = $urandom;
      ex_we    = ($urandom_range(0, 9) < 8);
      wb_ready = ($urandom_range(0, 9) < 5);
      raddr1   = ADDR_W'($urandom_range(0, 7));
      raddr2   = ADDR_W'($urandom_range(0, 7));
      @(negedge clk);
      check_model($sformatf("r%0d", c));
      finish_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
